// File: rtl/router_pkg.sv
// router_pkg: shared router constants, header field slices and arbiter FSM states.
// Header byte layout is {len[5:0], addr[1:0]}; used by router_in_arbiter and router_top.
package router_pkg;
  localparam int DATA_W  = 8;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  typedef enum logic [1:0] {IDLE, XFER, PARITY, GAP} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select starting one past the last grant.
// Ports: req (request vector), last (previous grant index) -> gnt (one-hot), idx (its index).
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  logic          found;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        gnt   = N'(1) << j;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/router_in_arbiter.sv
// router_in_arbiter: round-robin packet arbiter sharing the router input among NUM_SRC sources.
// Ports: clock/resetn (sync, active-low); src_valid/src_data/src_last/src_ready per-source byte
// handshake; busy router back-pressure; data_in/pkt_valid/grant registered router-side outputs;
// abort pulses when a granted source drops valid mid-packet; len_err pulses on a header length
// mismatch when ROUTER_ARB_LEN_CHECK_EN is defined, otherwise tied 0.
module router_in_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      busy,
  output logic [DATA_W-1:0]         data_in,
  output logic                      pkt_valid,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      abort,
  output logic                      len_err
);
  import router_pkg::*;
  localparam int IW = $clog2(NUM_SRC);
  state_t             state_q, state_d;
  logic [IW-1:0]      last_q, last_d, pick_idx;
  logic [NUM_SRC-1:0] grant_q, grant_d, pick_gnt;
  logic [DATA_W-1:0]  data_q, data_d, sel_data;
  logic               pkt_valid_q, pkt_valid_d, abort_q, abort_d, hdr_q, hdr_d;
  logic               sel_valid, sel_last, acc;
  rr_picker #(.N(NUM_SRC)) u_pick (
    .req  (src_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      sel_data = sel_data | (src_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
  end
  assign sel_valid = |(src_valid & grant_q);
  assign sel_last  = |(src_last & grant_q);
  assign src_ready = grant_q & {NUM_SRC{state_q == XFER && !busy}};
  assign acc       = state_q == XFER && !busy && sel_valid;
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    hdr_d       = hdr_q;
    abort_d     = 1'b0;
    unique case (state_q)
      IDLE: if (|src_valid) begin
        grant_d = pick_gnt;
        last_d  = pick_idx;
        hdr_d   = 1'b0;
        state_d = XFER;
      end
      XFER: if (acc) begin
        data_d      = sel_data;
        pkt_valid_d = !sel_last;
        hdr_d       = 1'b1;
        state_d     = sel_last ? PARITY : XFER;
      end else if (!busy && hdr_q) begin
        // source broke its contract mid-packet; the router will see a parity error
        data_d      = '0;
        pkt_valid_d = 1'b0;
        abort_d     = 1'b1;
        state_d     = GAP;
      end
      PARITY: if (!busy) begin
        data_d  = '0;
        state_d = GAP;
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_q      <= IW'(NUM_SRC - 1);
      grant_q     <= '0;
      data_q      <= '0;
      pkt_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      hdr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      abort_q     <= abort_d;
      hdr_q       <= hdr_d;
    end
  end
  assign data_in   = data_q;
  assign pkt_valid = pkt_valid_q;
  assign grant     = grant_q;
  assign abort     = abort_q;
`ifdef ROUTER_ARB_LEN_CHECK_EN
  logic [5:0] len_q, len_d, cnt_q, cnt_d;
  logic       len_err_q, len_err_d;
  // header byte captures the length; payload bytes are counted until the parity byte
  always_comb begin
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    if (acc && !hdr_q) begin
      len_d     = sel_data[LEN_MSB:LEN_LSB];
      cnt_d     = '0;
      len_err_d = sel_last && sel_data[LEN_MSB:LEN_LSB] != 6'd0;
    end else if (acc) begin
      cnt_d     = sel_last ? cnt_q : cnt_q + 6'd1;
      len_err_d = sel_last && cnt_q != len_q;
    end
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_in_arbiter.sv
// tb_router_in_arbiter: directed scoreboard bench for router_in_arbiter.
module tb_router_in_arbiter;
  localparam int N = 3;
  typedef struct packed {
    logic [1:0] src;
    logic [7:0] d;
    logic       pv;
    logic       hdr;
    logic       par;
  } ent_t;
  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           busy = 1'b0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_last = '0;
  logic [N*8-1:0] src_data = '0;
  logic [N-1:0]   src_ready, grant, last_rdy;
  logic [7:0]     data_in, d0;
  logic           pkt_valid, abort, len_err;
  logic [8:0]     sq [N][$];
  ent_t           exp_q [$];
  int             passed = 0, failed = 0, total = 0;
  int             cycle = 0, par_cyc = 0, len_err_cnt = 0, len_exp = 0;
  bit             have_par = 0;
  always #5 clock = ~clock;
  router_in_arbiter #(.NUM_SRC(N), .DATA_W(8)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .busy      (busy),
    .data_in   (data_in),
    .pkt_valid (pkt_valid),
    .grant     (grant),
    .abort     (abort),
    .len_err   (len_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input int s, input logic [1:0] addr, input int len, input int n, input bit full);
    logic [7:0] b, p;
    b = {6'(len), addr};
    p = b;
    sq[s].push_back({full && n == 0, b});
    exp_q.push_back(ent_t'{2'(s), b, !(full && n == 0), 1'b1, full && n == 0});
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      p ^= b;
      sq[s].push_back({1'b0, b});
      exp_q.push_back(ent_t'{2'(s), b, 1'b1, 1'b0, 1'b0});
    end
    if (full && n > 0) begin
      sq[s].push_back({1'b1, p});
      exp_q.push_back(ent_t'{2'(s), p, 1'b0, 1'b0, 1'b1});
    end
  endtask
  task automatic cyc();
    ent_t         e;
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) begin
      src_valid[i]       = sq[i].size() > 0;
      src_data[i*8 +: 8] = src_valid[i] ? sq[i][0][7:0] : 8'h00;
      src_last[i]        = src_valid[i] && sq[i][0][8];
    end
    #1;
    last_rdy = src_ready;
    hs = src_valid & src_ready & {N{resetn}};
    @(posedge clock);
    #1;
    cycle++;
    if (len_err === 1'b1) len_err_cnt++;
    for (int i = 0; i < N; i++)
      if (hs[i]) void'(sq[i].pop_front());
    if (|hs) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(data_in), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("data", 32'(data_in), 32'(e.d));
        chk("pkt_valid", 32'(pkt_valid), 32'(e.pv));
        chk("grant", 32'(grant), 32'(1 << e.src));
        if (e.hdr && have_par) chk("gap", 32'(cycle - par_cyc >= 4), 32'd1);
        if (e.par) begin
          par_cyc  = cycle;
          have_par = 1;
        end
      end
    end
  endtask
  task automatic drain(input int max, input int tail);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cyc();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (tail) cyc();
  endtask
  initial begin
`ifdef ROUTER_ARB_LEN_CHECK_EN
    len_exp = 1;
`endif
    repeat (2) cyc();
    chk("rst_data", 32'(data_in), 32'd0);
    chk("rst_pv", 32'(pkt_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    resetn = 1'b1;
    cyc();
    // all three request together; source 0 queues a second packet to show 0,1,2,0
    send(0, 2'd0, 14, 14, 1);
    send(1, 2'd1, 3, 3, 1);
    send(2, 2'd2, 5, 5, 1);
    send(0, 2'd3, 2, 2, 1);
    cyc();
    chk("grant_latency", 32'(grant), 32'b001);
    chk("pv_before_hdr", 32'(pkt_valid), 32'd0);
    cyc();
    chk("hdr_0x38", 32'(data_in), 32'h38);
    drain(400, 4);
    // back-pressure mid-payload
    send(1, 2'd1, 6, 6, 1);
    repeat (4) cyc();
    d0 = data_in;
    busy = 1'b1;
    repeat (4) begin
      cyc();
      chk("busy_hold", 32'(data_in), 32'(d0));
      chk("busy_pv", 32'(pkt_valid), 32'd1);
      chk("busy_ready", 32'(last_rdy), 32'd0);
    end
    busy = 1'b0;
    drain(100, 4);
    // zero-payload packet: header is the last byte
    send(2, 2'd1, 0, 0, 1);
    drain(20, 4);
    // source 1 stops after three payload bytes
    send(1, 2'd1, 8, 3, 0);
    drain(50, 0);
    cyc();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_pv", 32'(pkt_valid), 32'd0);
    chk("abort_data", 32'(data_in), 32'd0);
    cyc();
    chk("abort_once", 32'(abort), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    repeat (2) cyc();
    // header length 10 with only 9 payload bytes
    len_err_cnt = 0;
    send(0, 2'd2, 10, 9, 1);
    drain(100, 4);
    chk("len_err_count", 32'(len_err_cnt), 32'(len_exp));
    // reset during source 2 payload
    send(2, 2'd2, 8, 8, 1);
    repeat (4) cyc();
    resetn = 1'b0;
    cyc();
    chk("midrst_data", 32'(data_in), 32'd0);
    chk("midrst_pv", 32'(pkt_valid), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_abort", 32'(abort), 32'd0);
    sq[2].delete();
    exp_q.delete();
    have_par = 0;
    resetn = 1'b1;
    send(0, 2'd3, 5, 5, 1);
    cyc();
    chk("post_rst_grant", 32'(grant), 32'b001);
    drain(100, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
